router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Per-destination 16x8 packet FIFO in the 1x3 router, written by the router's input FSM/register stage and read by the destination port.
- Each entry carries a 9th tag bit marking header bytes.
- On reading a header it loads an internal packet-byte counter (payload length + 1) and releases data_out once the packet's parity byte has been read.
- Supports a per-port soft reset.

Parameters:
- WIDTH, 8, data byte width
- DEPTH, 16, number of entries
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits

Ports:
- clock  in  1  system clock; all logic on the rising edge
- resetn  in  1  synchronous, active-high reset (asserted = 1, despite the suffix)
- soft_reset  in  1  synchronous per-port flush, active-high
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  high while data_in carries a header byte; stored as tag bit 8
- data_in  in  8  byte to write
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- data_out  out  8  registered read data

Behaviour:
- Storage: DEPTH x 9-bit memory, {tag, byte}. wr_ptr and rd_ptr are 5 bits.
- Flags are combinational:
  - empty = (wr_ptr == rd_ptr)
  - full = (wr_ptr == {~rd_ptr[4], rd_ptr[3:0]})
  - Address = ptr[3:0]; wrap is natural modulo 16.
- resetn (highest priority):
  - pointers 0, all memory words 0, count 0, data_out 8'h00
  - after reset: empty=1, full=0
- soft_reset (when resetn=0):
  - pointers 0, count 0, data_out released (see Optional Feature)
  - memory contents are don't-care
- Write: if write_enb && !full, mem[wr_ptr[3:0]] <= {lfd_state, data_in} and wr_ptr++. A write while full is ignored with no state change.
- Read: if read_enb && !empty:
  - data_out <= mem[rd_ptr[3:0]][7:0] (one-cycle latency from the enabling edge); rd_ptr++.
  - If the tag bit is 1: count <= mem[rd_ptr][7:2] + 1 (6-bit payload length + 1 for parity).
  - Else if count != 0: count <= count - 1.
- A read while empty is ignored; pointers are unchanged.
- Release: when no read occurs in a cycle and count == 0, data_out is released.
  - data_out otherwise holds its last value between reads.
- Simultaneous read and write (not full, not empty) both complete in the same cycle; the occupancy is unchanged.
- When full, a simultaneous read and write performs only the read.
- When empty, a simultaneous read and write performs only the write; there is no fall-through, so the written byte is readable from the next cycle.
- count is 7 bits (max payload 63, + 1 = 64).
- Header byte format: [7:2] payload length, [1:0] destination address.

Optional Feature:
- Macro: ROUTER_FIFO_TRISTATE_EN
- Defined: the release value is 8'bz (high-impedance), for a shared output bus.
- Undefined: the release value is 8'h00, and all other behaviour is identical.
- Reset (resetn) always drives 8'h00 in both builds.

Decomposition:
- Shared package router_pkg holds:
  - localparams ROUTER_DATA_W=8, ROUTER_FIFO_DEPTH=16, ROUTER_FIFO_AW=4
  - header field positions: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0
- One natural sub-module, router_fifo_ctrl: pointers, full/empty and the packet counter. The memory array stays in the top module.

Test Plan:
- Reset: pulse resetn for one cycle -> empty=1, full=0, data_out=8'h00. Then pulse soft_reset for one cycle -> empty=1, data_out released (Z with macro, 00 without).
- Full packet fill:
  - Stimulus: header 8'h39 (len 14, addr 01) with lfd_state=1, then 14 random payload bytes and 1 parity byte with lfd_state=0, on consecutive cycles.
  - After the 16th write: full=1, empty=0.
  - A 17th write attempt leaves memory and pointers unchanged.
- Packet drain:
  - Two idle cycles, then read_enb=1, write_enb=0.
  - data_out sequence is 39, the payload bytes in order, then parity, one cycle after each read.
  - empty=1 after the 16th read. count=15 after the header read and reaches 0 after the parity read.
  - On the next cycle data_out is released.
- Simultaneous read/write with 5 entries stored: both enables high for 4 cycles -> occupancy stays 5, and the output order is FIFO.
- Wrap-around:
  - Write 10 bytes, read 10, write 16 more -> full=1.
  - The 16 bytes read back in order across the index 15->0 wrap.
- Soft reset mid-packet: after the header read plus 3 payload reads, assert soft_reset -> empty=1, count=0, data_out released, and no further bytes are readable.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: datapath sizes and header byte field positions.
// Header byte layout: [7:2] payload length, [1:0] destination port.
package router_pkg;

    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int ROUTER_FIFO_AW    = 4;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    // One extra bit so a maximum-length packet plus its parity byte fits.
    localparam int CNT_W = LEN_W + 1;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [ROUTER_DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_MSB-ADDR_LSB:0] hdr_dest(input logic [ROUTER_DATA_W-1:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_ctrl.sv
// FIFO control for router_fifo: read/write pointers, full/empty flags and the
// packet byte counter loaded from each header read out of the FIFO.
module router_fifo_ctrl
    import router_pkg::*;
#(
    parameter int ADDR_W = ROUTER_FIFO_AW
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              rd_tag,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              full,
    output logic              empty,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;

    // Pointers carry one extra lap bit so full and empty stay distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]});
    assign wr_en   = write_enb && !full;
    assign rd_en   = read_enb && !empty;
    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clock) begin
        if (resetn || soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                // Header: payload bytes plus the trailing parity byte.
                if (rd_tag) begin
                    count <= CNT_W'(rd_len) + CNT_W'(1);
                end else if (count != '0) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_fifo.sv
// Per-destination 16x9 packet FIFO of the 1x3 router; tag bit 8 marks headers.
// ROUTER_FIFO_TRISTATE_EN: released data_out floats (8'bz) instead of 8'h00.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH  = ROUTER_DATA_W,
    parameter int DEPTH  = ROUTER_FIFO_DEPTH,
    parameter int ADDR_W = ROUTER_FIFO_AW
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] RELEASE_VAL = 'z;
`else
    localparam logic [WIDTH-1:0] RELEASE_VAL = '0;
`endif

    logic [WIDTH:0]      mem [DEPTH];
    logic [WIDTH:0]      rd_word;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [CNT_W-1:0]    count;

    router_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .rd_tag     (rd_word[WIDTH]),
        .rd_len     (rd_word[LEN_MSB:LEN_LSB]),
        .full       (full),
        .empty      (empty),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .count      (count)
    );

    assign rd_word = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= {lfd_state, data_in};
        end
    end

    // Output is released once the whole packet (through parity) has left.
    always_ff @(posedge clock) begin
        if (resetn) begin
            data_out <= '0;
        end else if (soft_reset) begin
            data_out <= RELEASE_VAL;
        end else if (rd_en) begin
            data_out <= rd_word[WIDTH-1:0];
        end else if (count == '0) begin
            data_out <= RELEASE_VAL;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, packet fill/drain, simultaneous
// read/write, pointer wrap and soft reset in the middle of a packet.
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    logic [7:0] exp_q[$];
    logic [7:0] rel_val;
    int         n_cmp;
    int         n_bad;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle(input logic we, input logic re, input logic lfd, input logic [7:0] d);
        @(negedge clock);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr_byte(input logic lfd, input logic [7:0] d);
        cycle(1'b1, 1'b0, lfd, d);
        exp_q.push_back(d);
    endtask

    task automatic rd_byte(input string tag);
        logic [7:0] e;
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'h0, data_out}, {24'h0, e});
        end
    endtask

    task automatic rw_byte(input string tag, input logic [7:0] d);
        logic [7:0] e;
        cycle(1'b1, 1'b1, 1'b0, d);
        e = exp_q.pop_front();
        exp_q.push_back(d);
        check(tag, {24'h0, data_out}, {24'h0, e});
    endtask

    logic [7:0] payload [14];
    logic [7:0] parity;

    initial begin
`ifdef ROUTER_FIFO_TRISTATE_EN
        rel_val = 8'bz;
`else
        rel_val = 8'h00;
`endif
        n_cmp = 0;
        n_bad = 0;
        payload = '{8'h12, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h7E, 8'h81,
                    8'h5A, 8'hC3, 8'h09, 8'h66, 8'hD4, 8'h2B, 8'hF0};
        resetn = 1'b1; soft_reset = 1'b0;
        write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;

        // Reset, then soft reset
        @(posedge clock); #1;
        check("rst_empty", {31'h0, empty}, 32'd1);
        check("rst_full", {31'h0, full}, 32'd0);
        check("rst_dout", {24'h0, data_out}, 32'h00);
        @(negedge clock); resetn = 1'b0; soft_reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock); soft_reset = 1'b0;
        check("srst_empty", {31'h0, empty}, 32'd1);
        check("srst_dout", {24'h0, data_out}, {24'h0, rel_val});

        // Full packet fill: header 0x39 (len 14), 14 payload, parity
        parity = 8'h39;
        wr_byte(1'b1, 8'h39);
        for (int i = 0; i < 14; i++) begin
            wr_byte(1'b0, payload[i]);
            parity = parity ^ payload[i];
        end
        check("fill_full_pre", {31'h0, full}, 32'd0);
        wr_byte(1'b0, parity);
        check("fill_full", {31'h0, full}, 32'd1);
        check("fill_empty", {31'h0, empty}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 8'hAA);
        check("ovf_full", {31'h0, full}, 32'd1);
        check("ovf_wrptr", {27'h0, dut.u_ctrl.wr_ptr}, 32'd16);

        // Drain
        idle();
        idle();
        rd_byte("drain_hdr");
        check("cnt_hdr", {25'h0, dut.u_ctrl.count}, 32'd15);
        for (int i = 0; i < 14; i++) rd_byte("drain_pay");
        check("cnt_pre_par", {25'h0, dut.u_ctrl.count}, 32'd1);
        rd_byte("drain_par");
        check("cnt_par", {25'h0, dut.u_ctrl.count}, 32'd0);
        check("drain_empty", {31'h0, empty}, 32'd1);
        idle();
        check("drain_release", {24'h0, data_out}, {24'h0, rel_val});

        // Simultaneous read/write with 5 stored
        for (int i = 0; i < 5; i++) wr_byte(1'b0, 8'h51 + 8'(i));
        for (int i = 0; i < 4; i++) rw_byte("rw_out", 8'h61 + 8'(i));
        check("rw_occ", {27'h0, 5'(dut.u_ctrl.wr_ptr - dut.u_ctrl.rd_ptr)}, 32'd5);
        for (int i = 0; i < 5; i++) rd_byte("rw_tail");
        check("rw_empty", {31'h0, empty}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("rd_empty_ptr", {27'h0, dut.u_ctrl.rd_ptr}, 32'd25);

        // Wrap-around: 10 in, 10 out, 16 in across index 15->0
        for (int i = 0; i < 10; i++) wr_byte(1'b0, 8'h80 + 8'(i));
        for (int i = 0; i < 10; i++) rd_byte("wrap_a");
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'hB0 + 8'(i));
        check("wrap_full", {31'h0, full}, 32'd1);
        for (int i = 0; i < 16; i++) rd_byte("wrap_b");
        check("wrap_empty", {31'h0, empty}, 32'd1);

        // Soft reset mid-packet: header 0x21 (len 8) + 9 bytes
        wr_byte(1'b1, 8'h21);
        for (int i = 0; i < 9; i++) wr_byte(1'b0, 8'hE0 + 8'(i));
        rd_byte("mid_hdr");
        check("mid_cnt_hdr", {25'h0, dut.u_ctrl.count}, 32'd9);
        for (int i = 0; i < 3; i++) rd_byte("mid_pay");
        check("mid_cnt_pay", {25'h0, dut.u_ctrl.count}, 32'd6);
        idle();
        check("mid_hold", {24'h0, data_out}, 32'h000000E2);
        @(negedge clock); soft_reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock); soft_reset = 1'b0;
        exp_q.delete();
        check("mid_empty", {31'h0, empty}, 32'd1);
        check("mid_cnt", {25'h0, dut.u_ctrl.count}, 32'd0);
        check("mid_release", {24'h0, data_out}, {24'h0, rel_val});
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("mid_noread_empty", {31'h0, empty}, 32'd1);
        check("mid_noread_dout", {24'h0, data_out}, {24'h0, rel_val});
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
